ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pkg.sv | 23 ++
 rtl/ctrl_pipeline_if.sv | 38 +++
 rtl/ctrl_stage.sv | 50 +++++
 rtl/ctrl_pipeline.sv | 151 +++++++++++++++
 tb/tb_ctrl_pipeline.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the control pipeline: default bundle
//                geometry, default divide latency and the divide FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int c_CW_DEFAULT         = 16;
    localparam int c_STAGES_DEFAULT     = 3;
    localparam int c_DIV_CYCLES_DEFAULT = 32;

    // Divide sequencer states, explicitly one bit wide.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } divState_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_pipeline_if.sv
// ============================================================================
//  Module      : ctrl_pipeline_if
//  Description : Bundle of decode-side inputs and per-stage outputs of the
//                control pipeline. master = driver of decode/stall/flush,
//                slave = the pipeline itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_pipeline_if
    import ctrl_pkg::*;
#(
    parameter int CW     = c_CW_DEFAULT,
    parameter int STAGES = c_STAGES_DEFAULT
);

    logic [CW-1:0]        ctrl_d;
    logic                 div_start_d;
    logic [STAGES-1:0]    stall_i;
    logic [STAGES-1:0]    flush_i;
    logic [STAGES*CW-1:0] ctrl_o;
    logic [STAGES-1:0]    valid_o;
    logic                 div_busy_o;
    logic                 stall_d_o;

    modport master (
        output ctrl_d, div_start_d, stall_i, flush_i,
        input  ctrl_o, valid_o, div_busy_o, stall_d_o
    );

    modport slave (
        input  ctrl_d, div_start_d, stall_i, flush_i,
        output ctrl_o, valid_o, div_busy_o, stall_d_o
    );

endinterface

`default_nettype wire

// File: rtl/ctrl_stage.sv
// ============================================================================
//  Module      : ctrl_stage
//  Description : One pipeline slot: a CW-wide control register plus valid.
//                Priority flush > hold > bubble > load.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int CW = c_CW_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_flush,
    input  wire logic          i_hold,
    input  wire logic          i_bubble,
    input  wire logic [CW-1:0] i_ctrl,
    input  wire logic          i_valid,
    output logic      [CW-1:0] o_ctrl,
    output logic               o_valid
);

    logic [CW-1:0] r_ctrl;
    logic          r_valid;

    // Slot register: flush clears even while held; a held upstream feeds a bubble.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_ctrl  <= r_ctrl;
            r_valid <= r_valid;
        end else if (i_bubble) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= i_ctrl;
            r_valid <= i_valid;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/ctrl_pipeline.sv
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : Control-bundle pipeline after decode with per-stage stall and
//                flush, back-propagated holds and an optional multi-cycle
//                divide sequencer holding stage 0.
//                Optional feature macro: CTRL_PIPELINE_DIV_EN (divide FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int CW         = c_CW_DEFAULT,
    parameter int STAGES     = c_STAGES_DEFAULT,
    parameter int DIV_CYCLES = c_DIV_CYCLES_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ctrl_pipeline_if.slave  bus
);

    logic [STAGES-1:0] w_hold;
    logic              w_divHold;
    logic [CW-1:0]     w_stageCtrl  [STAGES];
    logic [STAGES-1:0] w_stageValid;

    // Holds ripple backwards: a stalled stage freezes everything upstream of it.
    always_comb begin
        w_hold             = '0;
        w_hold[STAGES-1]   = bus.stall_i[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_hold[k] = bus.stall_i[k] | w_hold[k+1];
        end
        w_hold[0] = w_hold[0] | w_divHold;
    end

    assign bus.stall_d_o = w_hold[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                ctrl_stage #(.CW(CW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .i_flush  (bus.flush_i[0]),
                    .i_hold   (w_hold[0]),
                    .i_bubble (1'b0),
                    .i_ctrl   (bus.ctrl_d),
                    .i_valid  (1'b1),
                    .o_ctrl   (w_stageCtrl[0]),
                    .o_valid  (w_stageValid[0])
                );
            end else begin : g_body
                ctrl_stage #(.CW(CW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .i_flush  (bus.flush_i[k]),
                    .i_hold   (w_hold[k]),
                    .i_bubble (w_hold[k-1]),
                    .i_ctrl   (w_stageCtrl[k-1]),
                    .i_valid  (w_stageValid[k-1]),
                    .o_ctrl   (w_stageCtrl[k]),
                    .o_valid  (w_stageValid[k])
                );
            end
        end
    endgenerate

    // Flatten the per-stage bundles onto the output bus.
    always_comb begin
        bus.ctrl_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.ctrl_o[k*CW +: CW] = w_stageCtrl[k];
        end
    end

    assign bus.valid_o = w_stageValid;

`ifdef CTRL_PIPELINE_DIV_EN
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    divState_t        r_state;
    divState_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_divStart;

    // The last busy cycle (counter 0) releases stage 0 so the divide spends
    // exactly DIV_CYCLES cycles there.
    assign w_divHold      = (r_state == BUSY) && (r_cnt != '0);
    assign bus.div_busy_o = (r_state == BUSY);

    // A divide starts only when it really advances into stage 0.
    assign w_divStart = bus.div_start_d & ~bus.flush_i[0] & ~w_hold[0];

    // Divide sequencer state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Divide sequencer next-state: flush aborts, expiry frees stage 0.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_divStart) begin
                    w_stateNext = BUSY;
                    w_cntNext   = c_CNT_LOAD;
                end
            end
            BUSY: begin
                if (bus.flush_i[0]) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == '0) begin
                    if (w_divStart) begin
                        w_stateNext = BUSY;
                        w_cntNext   = c_CNT_LOAD;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end
`else
    logic w_unusedDivStart;

    assign w_unusedDivStart = bus.div_start_d;
    assign w_divHold        = 1'b0;
    assign bus.div_busy_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Directed self-checking bench for ctrl_pipeline
//                (CW=16, STAGES=3, DIV_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipeline;

    localparam int CW         = 16;
    localparam int STAGES     = 3;
    localparam int DIV_CYCLES = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ctrl_pipeline_if #(.CW(CW), .STAGES(STAGES)) bus ();

    ctrl_pipeline #(
        .CW         (CW),
        .STAGES     (STAGES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pk(input logic [15:0] w, input logic [15:0] m, input logic [15:0] e);
        return {w, m, e};
    endfunction

    initial begin
        // Reset with noisy inputs: everything must stay cleared.
        rst             = 1'b1;
        bus.ctrl_d      = 16'hFFFF;
        bus.div_start_d = 1'b1;
        bus.stall_i     = 3'b000;
        bus.flush_i     = 3'b000;
        tick();
        tick();
        chk("rst_ctrl",    64'(bus.ctrl_o),     64'h0);
        chk("rst_valid",   64'(bus.valid_o),    64'h0);
        chk("rst_busy",    64'(bus.div_busy_o), 64'h0);
        chk("rst_stall_d", 64'(bus.stall_d_o),  64'h0);

        // Plain stream 1,2,3.
        rst             = 1'b0;
        bus.div_start_d = 1'b0;
        bus.ctrl_d      = 16'h0001;
        tick();
        chk("s1_ctrl",  64'(bus.ctrl_o),  64'(pk(16'h0, 16'h0, 16'h1)));
        chk("s1_valid", 64'(bus.valid_o), 64'h1);
        bus.ctrl_d = 16'h0002;
        tick();
        chk("s2_ctrl",  64'(bus.ctrl_o),  64'(pk(16'h0, 16'h1, 16'h2)));
        chk("s2_valid", 64'(bus.valid_o), 64'h3);
        bus.ctrl_d = 16'h0003;
        tick();
        chk("s3_ctrl",  64'(bus.ctrl_o),  64'(pk(16'h1, 16'h2, 16'h3)));
        chk("s3_valid", 64'(bus.valid_o), 64'h7);
        bus.ctrl_d = 16'h00A5;
        tick();
        bus.ctrl_d = 16'h00B6;
        tick();
        chk("s5_ctrl",  64'(bus.ctrl_o),  64'(pk(16'h3, 16'hA5, 16'hB6)));

        // Stall M for one cycle: E held, W bubbles, decode held.
        bus.ctrl_d  = 16'h00C7;
        bus.stall_i = 3'b010;
        #1;
        chk("stm_stall_d", 64'(bus.stall_d_o), 64'h1);
        tick();
        chk("stm_ctrl",  64'(bus.ctrl_o),  64'(pk(16'h0, 16'hA5, 16'hB6)));
        chk("stm_valid", 64'(bus.valid_o), 64'h3);
        bus.stall_i = 3'b000;
        #1;
        chk("stm_release", 64'(bus.stall_d_o), 64'h0);
        tick();
        chk("stm_after", 64'(bus.ctrl_o),  64'(pk(16'hA5, 16'hB6, 16'hC7)));
        chk("stm_avld",  64'(bus.valid_o), 64'h7);

        // Flush and stall on E together: flush wins, M gets a bubble.
        bus.ctrl_d  = 16'h00D8;
        bus.flush_i = 3'b001;
        bus.stall_i = 3'b001;
        #1;
        chk("fl_stall_d", 64'(bus.stall_d_o), 64'h1);
        tick();
        chk("fl_ctrl",  64'(bus.ctrl_o),  64'(pk(16'hB6, 16'h0, 16'h0)));
        chk("fl_valid", 64'(bus.valid_o), 64'h4);
        bus.flush_i = 3'b000;
        bus.stall_i = 3'b000;
        tick();
        chk("fl_next",  64'(bus.ctrl_o),  64'(pk(16'h0, 16'h0, 16'hD8)));
        chk("fl_nvld",  64'(bus.valid_o), 64'h1);

`ifdef CTRL_PIPELINE_DIV_EN
        // Divide: busy 4 cycles, decode held for the first 3, leaves E after 4.
        bus.ctrl_d      = 16'hD000;
        bus.div_start_d = 1'b1;
        tick();
        bus.div_start_d = 1'b0;
        bus.ctrl_d      = 16'h0E01;
        #1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            chk($sformatf("div_busy_c%0d", i),    64'(bus.div_busy_o), 64'h1);
            chk($sformatf("div_stall_d_c%0d", i), 64'(bus.stall_d_o),  64'(i < 4));
            chk($sformatf("div_e_c%0d", i),       64'(bus.ctrl_o[15:0]), 64'hD000);
        end
        tick();
        chk("div_done_busy", 64'(bus.div_busy_o), 64'h0);
        chk("div_done_ctrl", 64'(bus.ctrl_o),     64'(pk(16'h0, 16'hD000, 16'h0E01)));
        chk("div_done_vld",  64'(bus.valid_o),    64'h3);

        // Flush E on the second busy cycle aborts the divide.
        bus.ctrl_d      = 16'hD111;
        bus.div_start_d = 1'b1;
        tick();
        bus.div_start_d = 1'b0;
        bus.ctrl_d      = 16'h0F02;
        chk("dfl_busy_c1", 64'(bus.div_busy_o), 64'h1);
        tick();
        chk("dfl_busy_c2", 64'(bus.div_busy_o), 64'h1);
        bus.flush_i = 3'b001;
        tick();
        chk("dfl_busy", 64'(bus.div_busy_o),   64'h0);
        chk("dfl_e",    64'(bus.ctrl_o[15:0]), 64'h0);
        chk("dfl_ev",   64'(bus.valid_o[0]),   64'h0);
        bus.flush_i = 3'b000;
        #1;
        chk("dfl_stall_d", 64'(bus.stall_d_o), 64'h0);
        tick();
        chk("dfl_next", 64'(bus.ctrl_o[15:0]), 64'h0F02);

        // Reset in the middle of a divide clears everything.
        bus.ctrl_d      = 16'hD222;
        bus.div_start_d = 1'b1;
        tick();
        chk("drst_busy_pre", 64'(bus.div_busy_o), 64'h1);
        bus.div_start_d = 1'b0;
        rst             = 1'b1;
        tick();
        chk("drst_ctrl",    64'(bus.ctrl_o),     64'h0);
        chk("drst_valid",   64'(bus.valid_o),    64'h0);
        chk("drst_busy",    64'(bus.div_busy_o), 64'h0);
        chk("drst_stall_d", 64'(bus.stall_d_o),  64'h0);
        rst        = 1'b0;
        bus.ctrl_d = 16'h1234;
        tick();
        chk("drst_first", 64'(bus.ctrl_o),     64'(pk(16'h0, 16'h0, 16'h1234)));
        chk("drst_fbusy", 64'(bus.div_busy_o), 64'h0);
`else
        // Without the divide option, div_start_d has no effect.
        bus.ctrl_d      = 16'hD000;
        bus.div_start_d = 1'b1;
        #1;
        chk("nd_stall_d0", 64'(bus.stall_d_o), 64'h0);
        tick();
        chk("nd_busy", 64'(bus.div_busy_o),   64'h0);
        chk("nd_e",    64'(bus.ctrl_o[15:0]), 64'hD000);
        bus.div_start_d = 1'b0;
        bus.ctrl_d      = 16'h0E01;
        #1;
        chk("nd_stall_d1", 64'(bus.stall_d_o), 64'h0);
        tick();
        chk("nd_ctrl",  64'(bus.ctrl_o),  64'(pk(16'hD8, 16'hD000, 16'h0E01)));
        chk("nd_valid", 64'(bus.valid_o), 64'h7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
